// File: rtl/adc_lvds_pkg.sv
// rtl/adc_lvds_pkg.sv - shared state encoding, default frame pattern and counter-width helper for the LVDS ADC path
package adc_lvds_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOCK_WAIT = 3'd1,
        CHECK     = 3'd2,
        SLIP      = 3'd3,
        SETTLE    = 3'd4,
        ALIGNED   = 3'd5,
        FAIL      = 3'd6
    } align_state_t;

    localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_bit_sync.sv
// rtl/adc_bit_sync.sv - two-flop synchronizer for a single asynchronous level
module adc_bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_frame_aligner.sv
// rtl/adc_frame_aligner.sv - FCLK bitslip alignment controller; ADC_FRAME_REALIGN_EN enables miss-triggered realign
module adc_frame_aligner
    import adc_lvds_pkg::*;
#(
    parameter int                      SERDES_WIDTH  = 8,
    parameter logic [SERDES_WIDTH-1:0] FRAME_PATTERN = SERDES_WIDTH'(DEFAULT_FRAME_PATTERN),
    parameter int                      LOCK_DELAY    = 64,
    parameter int                      SETTLE_CYCLES = 4,
    parameter int                      MATCH_COUNT   = 16,
    parameter int                      MAX_SLIPS     = 16,
    parameter int                      MISS_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          locked,
    input  logic [SERDES_WIDTH-1:0]       frame_data,
    input  logic                          realign_req,
    output logic                          bitslip,
    output logic                          aligned,
    output logic                          align_fail,
    output logic [cnt_w(MAX_SLIPS)-1:0]   slip_count,
    output logic [2:0]                    state_dbg
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_LOCK_WAIT = LOCK_WAIT;
    localparam logic [2:0] S_CHECK     = CHECK;
    localparam logic [2:0] S_SLIP      = SLIP;
    localparam logic [2:0] S_SETTLE    = SETTLE;
    localparam logic [2:0] S_ALIGNED   = ALIGNED;
    localparam logic [2:0] S_FAIL      = FAIL;

    // One delay counter serves both the post-lock wait and the post-slip settle window.
    localparam int DLY_MAX = (LOCK_DELAY > SETTLE_CYCLES) ? LOCK_DELAY : SETTLE_CYCLES;
    localparam int DLY_W   = cnt_w(DLY_MAX);
    localparam int MATCH_W = cnt_w(MATCH_COUNT);
    localparam int SLIP_W  = cnt_w(MAX_SLIPS);

    localparam logic [DLY_W-1:0]   LD_LAST  = DLY_W'(LOCK_DELAY - 1);
    localparam logic [DLY_W-1:0]   SC_LAST  = DLY_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MC_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [SLIP_W-1:0]  SLIP_MAX = SLIP_W'(MAX_SLIPS);

    logic               lock_s;
    logic [2:0]         state, next_state;
    logic [DLY_W-1:0]   delay_cnt, delay_nxt;
    logic [MATCH_W-1:0] match_cnt, match_nxt;
    logic [SLIP_W-1:0]  slip_cnt, slip_nxt;
    logic               word_ok;

`ifdef ADC_FRAME_REALIGN_EN
    localparam int                MISS_W    = cnt_w(MISS_COUNT);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_COUNT - 1);
    logic [MISS_W-1:0] miss_cnt, miss_nxt;
`endif

    adc_bit_sync u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (locked),
        .q     (lock_s)
    );

    assign word_ok = (frame_data == FRAME_PATTERN);

    always_comb begin
        next_state = state;
        delay_nxt  = delay_cnt;
        match_nxt  = match_cnt;
        slip_nxt   = slip_cnt;
`ifdef ADC_FRAME_REALIGN_EN
        miss_nxt   = miss_cnt;
`endif
        if (!lock_s || (realign_req && state != S_IDLE)) begin
            next_state = lock_s ? S_LOCK_WAIT : S_IDLE;
            delay_nxt  = '0;
            match_nxt  = '0;
            slip_nxt   = '0;
`ifdef ADC_FRAME_REALIGN_EN
            miss_nxt   = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    next_state = S_LOCK_WAIT;
                    delay_nxt  = '0;
                end
                S_LOCK_WAIT: begin
                    if (delay_cnt == LD_LAST) begin
                        next_state = S_CHECK;
                        delay_nxt  = '0;
                        match_nxt  = '0;
                        slip_nxt   = '0;
                    end else begin
                        delay_nxt = delay_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (word_ok) begin
                        if (match_cnt == MC_LAST) begin
                            next_state = S_ALIGNED;
                            match_nxt  = '0;
                        end else begin
                            match_nxt = match_cnt + 1'b1;
                        end
                    end else begin
                        match_nxt  = '0;
                        next_state = (slip_cnt < SLIP_MAX) ? S_SLIP : S_FAIL;
                    end
                end
                S_SLIP: begin
                    if (slip_cnt != SLIP_MAX)
                        slip_nxt = slip_cnt + 1'b1;
                    next_state = S_SETTLE;
                    delay_nxt  = '0;
                end
                S_SETTLE: begin
                    if (delay_cnt == SC_LAST) begin
                        next_state = S_CHECK;
                        delay_nxt  = '0;
                    end else begin
                        delay_nxt = delay_cnt + 1'b1;
                    end
                end
                S_ALIGNED: begin
`ifdef ADC_FRAME_REALIGN_EN
                    if (word_ok) begin
                        miss_nxt = '0;
                    end else if (miss_cnt == MISS_LAST) begin
                        next_state = S_CHECK;
                        miss_nxt   = '0;
                        match_nxt  = '0;
                        slip_nxt   = '0;
                    end else begin
                        miss_nxt = miss_cnt + 1'b1;
                    end
`endif
                end
                S_FAIL: ;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Flags are registered from next_state so they track the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            delay_cnt  <= '0;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
        end else begin
            state      <= next_state;
            delay_cnt  <= delay_nxt;
            match_cnt  <= match_nxt;
            slip_cnt   <= slip_nxt;
            bitslip    <= (next_state == S_SLIP);
            aligned    <= (next_state == S_ALIGNED);
            align_fail <= (next_state == S_FAIL);
        end
    end

`ifdef ADC_FRAME_REALIGN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            miss_cnt <= '0;
        else
            miss_cnt <= miss_nxt;
    end
`endif

    assign slip_count = slip_cnt;
    assign state_dbg  = state;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb/tb_adc_frame_aligner.sv - directed self-checking bench for adc_frame_aligner
module tb_adc_frame_aligner;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic [7:0] frame_data;
    logic       realign_req;
    logic       bitslip;
    logic       aligned;
    logic       align_fail;
    logic [4:0] slip_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -1000;
    int min_sp = 1000;
    bit rot_mode = 1'b0;
    int saved;
    bit seen;

    always #5 clk = ~clk;

    adc_frame_aligner dut (
        .clk         (clk),
        .reset       (reset),
        .locked      (locked),
        .frame_data  (frame_data),
        .realign_req (realign_req),
        .bitslip     (bitslip),
        .aligned     (aligned),
        .align_fail  (align_fail),
        .slip_count  (slip_count),
        .state_dbg   (state_dbg)
    );

    always @(posedge clk) cyc++;

    // Pulse monitor; in rotate mode it models the ISERDES shifting the word by one bit per slip.
    always @(negedge clk) begin
        if (bitslip === 1'b1) begin
            pulses++;
            if (cyc - last_pulse < min_sp) min_sp = cyc - last_pulse;
            last_pulse = cyc;
            if (rot_mode) frame_data = {frame_data[6:0], frame_data[7]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        locked = 1'b0;
        realign_req = 1'b0;
        rot_mode = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        min_sp = 1000;
        last_pulse = -1000;
    endtask

    initial begin
        reset = 1'b1;
        locked = 1'b0;
        frame_data = 8'h00;
        realign_req = 1'b0;

        @(negedge clk);
        chk("rst_bitslip", 32'(bitslip), 0);
        chk("rst_aligned", 32'(aligned), 0);
        chk("rst_fail", 32'(align_fail), 0);
        chk("rst_slips", 32'(slip_count), 0);
        chk("rst_state", 32'(state_dbg), 0);

        // Test 1: already aligned -> aligned after 64+16+3 edges, no slips.
        do_reset();
        locked = 1'b1;
        frame_data = 8'hF0;
        repeat (82) @(negedge clk);
        chk("t1_aligned_early", 32'(aligned), 0);
        @(negedge clk);
        chk("t1_aligned", 32'(aligned), 1);
        chk("t1_state", 32'(state_dbg), 5);
        chk("t1_slips", 32'(slip_count), 0);
        chk("t1_pulses", 32'(pulses), 0);

`ifdef ADC_FRAME_REALIGN_EN
        // Test 5: three misses tolerated, four trigger realignment.
        frame_data = 8'h00;
        repeat (3) @(negedge clk);
        frame_data = 8'hF0;
        repeat (2) @(negedge clk);
        chk("t5_three_miss_aligned", 32'(aligned), 1);
        frame_data = 8'h00;
        repeat (4) @(negedge clk);
        chk("t5_four_miss_aligned", 32'(aligned), 0);
        chk("t5_four_miss_state", 32'(state_dbg), 2);
        frame_data = 8'hF0;
        repeat (16) @(negedge clk);
        chk("t5_realigned", 32'(aligned), 1);
        chk("t5_slips", 32'(slip_count), 0);
`else
        frame_data = 8'h00;
        repeat (8) @(negedge clk);
        chk("t5_sticky_aligned", 32'(aligned), 1);
        chk("t5_sticky_state", 32'(state_dbg), 5);
`endif

        // Test 2: rotating word starting at 1E needs three slips.
        do_reset();
        frame_data = 8'h1E;
        rot_mode = 1'b1;
        locked = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (aligned === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t2_aligned_seen", 32'(seen), 1);
        chk("t2_pulses", 32'(pulses), 3);
        chk("t2_slips", 32'(slip_count), 3);
        chk("t2_spacing_ok", 32'(min_sp >= 6), 1);
        chk("t2_word", 32'(frame_data), 32'h0F0);

        // Test 3: never-matching word exhausts the slip budget.
        do_reset();
        frame_data = 8'hAA;
        locked = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (align_fail === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t3_fail_seen", 32'(seen), 1);
        chk("t3_pulses", 32'(pulses), 16);
        chk("t3_slips", 32'(slip_count), 16);
        chk("t3_spacing", 32'(min_sp), 6);
        chk("t3_state", 32'(state_dbg), 6);
        repeat (20) @(negedge clk);
        chk("t3_no_more_pulses", 32'(pulses), 16);
        chk("t3_fail_held", 32'(align_fail), 1);
        chk("t3_not_aligned", 32'(aligned), 0);
        realign_req = 1'b1;
        @(negedge clk);
        realign_req = 1'b0;
        chk("t3_realign_state", 32'(state_dbg), 1);
        chk("t3_realign_fail", 32'(align_fail), 0);
        chk("t3_realign_slips", 32'(slip_count), 0);

        // Test 4: lock loss at the start of SETTLE.
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (state_dbg === 3'd4) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_settle_seen", 32'(seen), 1);
        saved = pulses;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_state", 32'(state_dbg), 0);
        chk("t4_aligned", 32'(aligned), 0);
        chk("t4_fail", 32'(align_fail), 0);
        chk("t4_slips", 32'(slip_count), 0);
        repeat (10) @(negedge clk);
        chk("t4_no_pulse", 32'(pulses), 32'(saved));

        // Test 6: asynchronous reset while in SLIP.
        locked = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bitslip === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_slip_seen", 32'(seen), 1);
        chk("t6_in_slip", 32'(state_dbg), 3);
        #1 reset = 1'b1;
        #1;
        chk("t6_async_bitslip", 32'(bitslip), 0);
        chk("t6_async_state", 32'(state_dbg), 0);
        chk("t6_async_slips", 32'(slip_count), 0);
        chk("t6_async_aligned", 32'(aligned), 0);
        chk("t6_async_fail", 32'(align_fail), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_idle_after_release", 32'(state_dbg), 0);
        @(negedge clk);
        chk("t6_lock_wait", 32'(state_dbg), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
